// File: rtl/trigger_arbiter.sv
// Four-source trigger arbiter: sync-slot sampling, one-deep request latches,
// round-robin grant, programmable dead time, issued/dropped trigger counters.
module trigger_arbiter #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync,
    input  logic             enable,
    input  logic [3:0]       src_mask,
    input  logic [7:0]       deadtime,
    input  logic [3:0]       req,
    input  logic [4*N-1:0]   req_data,
    input  logic             clr_cnt,
    output logic             trg_out,
    output logic [N-1:0]     data_out,
    output logic [1:0]       src_out,
    output logic             busy,
    output logic [15:0]      trg_cnt,
    output logic [15:0]      drop_cnt
);

    logic [3:0]          pending_q, pending_d;
    logic [3:0][N-1:0]   held_q, held_d;
    logic [1:0]          rr_q, rr_d;
    logic [7:0]          dcnt_q, dcnt_d;
    logic                trg_q, trg_d;
    logic [N-1:0]        data_q, data_d;
    logic [1:0]          src_q, src_d;
    logic                busy_q, busy_d;
    logic [15:0]         trg_cnt_q, trg_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic [3:0]          q_s;
    logic [3:0]          cand_s;
    logic                found_s;
    logic                grant_s;
    logic [1:0]          win_s;
    logic [1:0]          idx_s;
    logic                hit_s;
    logic [N-1:0]        win_data_s;
    logic [2:0]          ndrop_s;
    logic [16:0]         drop_sum_s;

    // Round-robin winner search starting one past the last granted source.
    always_comb begin
        q_s     = req & src_mask & {4{sync & enable}};
        cand_s  = (pending_q & src_mask) | q_s;
        found_s = 1'b0;
        win_s   = 2'd0;
        idx_s   = 2'd0;
        hit_s   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx_s   = rr_q + 2'(k);
            hit_s   = cand_s[idx_s] & ~found_s;
            win_s   = hit_s ? idx_s : win_s;
            found_s = found_s | hit_s;
        end
        grant_s    = found_s & sync & enable & (dcnt_q == 8'd0);
        win_data_s = pending_q[win_s] ? held_q[win_s] : req_data[win_s*N +: N];
    end

    // Next-state: latching, drops, grant outputs, dead time and counters.
    always_comb begin
        pending_d  = pending_q;
        held_d     = held_q;
        rr_d       = rr_q;
        dcnt_d     = dcnt_q;
        trg_d      = trg_q;
        data_d     = data_q;
        src_d      = src_q;
        trg_cnt_d  = trg_cnt_q;
        ndrop_s    = 3'd0;

        for (int i = 0; i < 4; i++) begin
            if (q_s[i]) begin
                if (grant_s && (win_s == 2'(i))) begin
                    // A pending winner goes out with held data; the fresh request re-latches.
                    held_d[i] = pending_q[i] ? req_data[i*N +: N] : held_q[i];
                end else if (pending_q[i]) begin
                    ndrop_s = ndrop_s + 3'd1;
                end else begin
                    pending_d[i] = 1'b1;
                    held_d[i]    = req_data[i*N +: N];
                end
            end else if (grant_s && (win_s == 2'(i))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end

        if (grant_s) begin
            trg_d     = 1'b1;
            data_d    = win_data_s;
            src_d     = win_s;
            rr_d      = win_s;
            dcnt_d    = deadtime;
            trg_cnt_d = trg_cnt_q + 16'd1;
        end else if (sync) begin
            trg_d  = 1'b0;
            data_d = '0;
            dcnt_d = (dcnt_q != 8'd0) ? (dcnt_q - 8'd1) : dcnt_q;
        end else begin
            trg_d = trg_q;
        end

        drop_sum_s = {1'b0, drop_cnt_q} + {14'd0, ndrop_s};
        drop_cnt_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];

        if (!enable) begin
            pending_d = 4'd0;
            dcnt_d    = 8'd0;
        end else begin
            pending_d = pending_d;
        end
        pending_d = pending_d & src_mask;

        if (clr_cnt) begin
            trg_cnt_d  = 16'd0;
            drop_cnt_d = 16'd0;
        end else begin
            trg_cnt_d = trg_cnt_d;
        end

        busy_d = (dcnt_d != 8'd0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 4'd0;
            held_q     <= '0;
            rr_q       <= 2'd3;
            dcnt_q     <= 8'd0;
            trg_q      <= 1'b0;
            data_q     <= '0;
            src_q      <= 2'd0;
            busy_q     <= 1'b0;
            trg_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            pending_q  <= pending_d;
            held_q     <= held_d;
            rr_q       <= rr_d;
            dcnt_q     <= dcnt_d;
            trg_q      <= trg_d;
            data_q     <= data_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            trg_cnt_q  <= trg_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign trg_out  = trg_q;
    assign data_out = data_q;
    assign src_out  = src_q;
    assign busy     = busy_q;
    assign trg_cnt  = trg_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Self-checking bench for trigger_arbiter: directed scenarios plus randomized
// traffic compared against a slot-level behavioural model.
module tb_trigger_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            sync;
    logic            enable;
    logic [3:0]      src_mask;
    logic [7:0]      deadtime;
    logic [3:0]      req;
    logic [4*N-1:0]  req_data;
    logic            clr_cnt;
    logic            trg_out;
    logic [N-1:0]    data_out;
    logic [1:0]      src_out;
    logic            busy;
    logic [15:0]     trg_cnt;
    logic [15:0]     drop_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_pend[4];
    int m_held[4];
    int m_rr, m_dead, m_trg, m_data, m_src, m_busy, m_tcnt, m_drop;

    trigger_arbiter #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .sync(sync), .enable(enable),
        .src_mask(src_mask), .deadtime(deadtime), .req(req), .req_data(req_data),
        .clr_cnt(clr_cnt), .trg_out(trg_out), .data_out(data_out), .src_out(src_out),
        .busy(busy), .trg_cnt(trg_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int src_data(input int i);
        return int'((req_data >> (i * N)) & 12'h7);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_held[i] = 0;
        end
        m_rr = 3; m_dead = 0; m_trg = 0; m_data = 0; m_src = 0;
        m_busy = 0; m_tcnt = 0; m_drop = 0;
    endtask

    task automatic model_step();
        bit q[4];
        int win = -1;
        int ndrop = 0;
        for (int i = 0; i < 4; i++)
            q[i] = sync && enable && req[i] && src_mask[i];
        if (sync && enable && m_dead == 0) begin
            for (int k = 1; k <= 4; k++) begin
                int i = (m_rr + k) % 4;
                if (win < 0 && ((m_pend[i] && src_mask[i]) || q[i])) win = i;
            end
        end
        if (win >= 0) begin
            m_trg  = 1;
            m_data = m_pend[win] ? m_held[win] : src_data(win);
            m_src  = win;
            m_rr   = win;
            m_dead = int'(deadtime);
            m_tcnt = (m_tcnt + 1) % 65536;
        end else if (sync) begin
            m_trg  = 0;
            m_data = 0;
            if (m_dead > 0) m_dead--;
        end
        for (int i = 0; i < 4; i++) begin
            if (q[i]) begin
                if (i == win) begin
                    if (m_pend[i]) m_held[i] = src_data(i);
                end else if (m_pend[i]) begin
                    ndrop++;
                end else begin
                    m_pend[i] = 1'b1;
                    m_held[i] = src_data(i);
                end
            end else if (i == win) begin
                m_pend[i] = 1'b0;
            end
        end
        if (!enable) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            m_dead = 0;
        end
        for (int i = 0; i < 4; i++)
            if (!src_mask[i]) m_pend[i] = 1'b0;
        m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
        if (clr_cnt) begin
            m_tcnt = 0;
            m_drop = 0;
        end
        m_busy = (m_dead != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; sync = 1'b0; enable = 1'b1; src_mask = 4'hF;
        deadtime = 8'd0; req = 4'd0; req_data = '0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One sync slot with request vector r, followed by gap non-sync cycles.
    task automatic do_slot(input logic [3:0] r, input int gap);
        req  = r;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int g = 0; g < gap; g++) begin
            req = 4'($urandom);
            tick();
        end
        req = 4'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({trg_out, data_out, src_out, busy, trg_cnt, drop_cnt} !== 39'd0) begin
            errors++;
            $display("FAIL reset_values: got trg=%0b data=%0d src=%0d busy=%0b tcnt=%0d dcnt=%0d, want all 0",
                     trg_out, data_out, src_out, busy, trg_cnt, drop_cnt);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_data = 12'(5 << (2 * N));
        do_slot(4'b0100, 2);
        checks++;
        if ({trg_out, data_out, src_out, trg_cnt, drop_cnt} !== {1'b1, 3'd5, 2'd2, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL single_grant: got trg=%0b data=%0d src=%0d tcnt=%0d drop=%0d, want 1 5 2 1 0",
                     trg_out, data_out, src_out, trg_cnt, drop_cnt);
        end
        do_slot(4'b0000, 1);
        checks++;
        if ({trg_out, data_out, src_out} !== {1'b0, 3'd0, 2'd2}) begin
            errors++;
            $display("FAIL single_release: got trg=%0b data=%0d src=%0d, want 0 0 2",
                     trg_out, data_out, src_out);
        end
    endtask

    task automatic test_all_four();
        int exp_d[4] = '{6, 1, 7, 3};
        apply_reset();
        req_data = {3'd3, 3'd7, 3'd1, 3'd6};
        for (int s = 0; s < 4; s++) begin
            do_slot((s == 0) ? 4'hF : 4'h0, 1);
            checks++;
            if ({trg_out, data_out, src_out} !== {1'b1, 3'(exp_d[s]), 2'(s)}) begin
                errors++;
                $display("FAIL all_four slot %0d: got trg=%0b data=%0d src=%0d, want 1 %0d %0d",
                         s, trg_out, data_out, src_out, exp_d[s], s);
            end
        end
        checks++;
        if (trg_cnt !== 16'd4) begin
            errors++;
            $display("FAIL all_four_count: got %0d want 4", trg_cnt);
        end
    endtask

    task automatic test_deadtime();
        bit exp_trg[5]  = '{1, 0, 0, 0, 1};
        bit exp_busy[5] = '{1, 1, 1, 0, 0};
        apply_reset();
        deadtime = 8'd3;
        for (int s = 0; s < 5; s++) begin
            do_slot((s == 0 || s == 2) ? 4'b0010 : 4'b0000, 1);
            if (s == 0) deadtime = 8'd0;
            checks++;
            if (trg_out !== exp_trg[s] || busy !== exp_busy[s]) begin
                errors++;
                $display("FAIL deadtime slot %0d: got trg=%0b busy=%0b, want %0b %0b",
                         s, trg_out, busy, exp_trg[s], exp_busy[s]);
            end
        end
        checks++;
        if (src_out !== 2'd1 || trg_cnt !== 16'd2) begin
            errors++;
            $display("FAIL deadtime_final: got src=%0d tcnt=%0d, want 1 2", src_out, trg_cnt);
        end
    endtask

    task automatic test_drop();
        apply_reset();
        deadtime = 8'd5;
        for (int s = 0; s < 7; s++) begin
            req_data = 12'(s + 1);
            do_slot((s <= 2) ? 4'b0001 : 4'b0000, 1);
            checks++;
            if (trg_out !== ((s == 0 || s == 6) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL drop_trg slot %0d: got %0b", s, trg_out);
            end
            if (s == 0 || s == 6) begin
                checks++;
                if (data_out !== ((s == 0) ? 3'd1 : 3'd2)) begin
                    errors++;
                    $display("FAIL drop_data slot %0d: got %0d want %0d", s, data_out, (s == 0) ? 1 : 2);
                end
            end
        end
        checks++;
        if (trg_cnt !== 16'd2 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop_counts: got tcnt=%0d drop=%0d, want 2 1", trg_cnt, drop_cnt);
        end
    endtask

    task automatic test_flush_mask();
        bit any_trg = 1'b0;
        apply_reset();
        deadtime = 8'd4;
        req_data = 12'(2 << (3 * N));
        do_slot(4'b1000, 1);
        req_data = 12'(5 << (3 * N));
        do_slot(4'b1000, 1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got %0b want 0", busy);
        end
        for (int s = 0; s < 6; s++) begin
            do_slot(4'b0000, 1);
            any_trg |= trg_out;
        end
        checks++;
        if (any_trg !== 1'b0 || trg_cnt !== 16'd1) begin
            errors++;
            $display("FAIL flush_no_grant: got any_trg=%0b tcnt=%0d, want 0 1", any_trg, trg_cnt);
        end
        src_mask = 4'b1101;
        deadtime = 8'd0;
        do_slot(4'b0010, 1);
        do_slot(4'b0010, 1);
        checks++;
        if (trg_out !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL masked_req: got trg=%0b drop=%0d, want 0 0", trg_out, drop_cnt);
        end
        src_mask = 4'hF;
        do_slot(4'b0000, 1);
        checks++;
        if (trg_out !== 1'b0 || trg_cnt !== 16'd1) begin
            errors++;
            $display("FAIL masked_unmask: got trg=%0b tcnt=%0d, want 0 1", trg_out, trg_cnt);
        end
    endtask

    task automatic test_drop_saturate();
        int guard = 0;
        apply_reset();
        deadtime = 8'd255;
        sync = 1'b1;
        while (m_drop < 65534 && guard < 30000) begin
            int rem = 65534 - m_drop;
            req = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            tick();
            guard++;
        end
        req = 4'd0;
        while (m_dead < 2 && guard < 31000) begin
            tick();
            guard++;
        end
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL drop_preload: got %0h want fffe", drop_cnt);
        end
        req = 4'b0011;
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_two_sat: got %0h want ffff", drop_cnt);
        end
        req = 4'hF;
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_hold_sat: got %0h want ffff", drop_cnt);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        req = 4'd0;
        sync = 1'b0;
        checks++;
        if (trg_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_cnt: got tcnt=%0d drop=%0d, want 0 0", trg_cnt, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        deadtime = 8'd20;
        req_data = {3'd0, 3'd0, 3'd6, 3'd3};
        do_slot(4'b0001, 1);
        do_slot(4'b0010, 1);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({trg_out, data_out, src_out, busy, trg_cnt, drop_cnt} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid: got trg=%0b data=%0d src=%0d busy=%0b tcnt=%0d drop=%0d, want all 0",
                     trg_out, data_out, src_out, busy, trg_cnt, drop_cnt);
        end
        #2;
        reset_n = 1'b1;
        for (int s = 0; s < 3; s++) do_slot(4'b0000, 1);
        checks++;
        if (trg_out !== 1'b0 || trg_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_pending_lost: got trg=%0b tcnt=%0d, want 0 0", trg_out, trg_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            sync     = ($urandom % 3) == 0;
            req      = 4'($urandom);
            req_data = 12'($urandom);
            enable   = ($urandom % 60) != 0;
            clr_cnt  = ($urandom % 300) == 0;
            if (($urandom % 8) == 0) deadtime = 8'($urandom % 4);
            if (!sync && ($urandom % 40) == 0) src_mask = 4'($urandom);
            tick();
            checks++;
            if ({trg_out, data_out, src_out, busy, trg_cnt, drop_cnt} !==
                {1'(m_trg), 3'(m_data), 2'(m_src), 1'(m_busy), 16'(m_tcnt), 16'(m_drop)}) begin
                errors++;
                $display("FAIL random cycle %0d: got trg=%0b data=%0d src=%0d busy=%0b tcnt=%0d drop=%0d, want %0d %0d %0d %0d %0d %0d",
                         c, trg_out, data_out, src_out, busy, trg_cnt, drop_cnt,
                         m_trg, m_data, m_src, m_busy, m_tcnt, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_deadtime();
        test_drop();
        test_flush_mask();
        test_reset_mid();
        test_drop_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
